// File: rtl/toggle_chk_pkg.sv
// toggle_chk_pkg: shared state encoding and sizing helpers for toggle_window_checker
package toggle_chk_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, CHECK} state_t;
    localparam int FAIL_CNT_W = 8;
    function automatic int cnt_w(input int max_cyc);
        return $clog2(max_cyc + 3);
    endfunction
endpackage

// File: rtl/toggle_window_checker_detect.sv
// toggle_detect: registers sig and flags a change against the previous cycle
module toggle_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic toggled
);
    logic sig_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) sig_q <= 1'b0;
        else      sig_q <= sig;
    assign toggled = sig ^ sig_q;
endmodule

// File: rtl/toggle_window_checker.sv
// toggle_window_checker: checks sig toggles every cycle in a window after start; TOGGLE_WINDOW_CHECKER_STICKY_EN adds fail_sticky/fail_cnt
module toggle_window_checker
    import toggle_chk_pkg::*;
#(
    parameter  int MIN_CYC = 1,
    parameter  int MAX_CYC = 12,
    localparam int CNT_W   = cnt_w(MAX_CYC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sig,
    output logic                  busy,
    output logic                  pass,
    output logic                  fail,
`ifdef TOGGLE_WINDOW_CHECKER_STICKY_EN
    output logic                  fail_sticky,
    output logic [FAIL_CNT_W-1:0] fail_cnt,
`endif
    output logic [CNT_W-1:0]      fail_off
);
    if (MIN_CYC < 1 || MIN_CYC > MAX_CYC || MAX_CYC > 254) begin : g_bad_cfg
        $error("toggle_window_checker: need 1 <= MIN_CYC <= MAX_CYC <= 254");
    end
    state_t state, state_n;
    logic [CNT_W-1:0] off_cnt, off_n;
    logic toggled, pass_n, fail_n;
    toggle_detect u_det (
        .clk     (clk),
        .rst     (rst),
        .sig     (sig),
        .toggled (toggled)
    );
    always_comb begin
        state_n = state;
        off_n   = off_cnt;
        pass_n  = 1'b0;
        fail_n  = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_n = ARMED;
                off_n   = CNT_W'(1);
            end
            ARMED: begin
                off_n   = off_cnt + 1'b1;
                state_n = (off_cnt == CNT_W'(MIN_CYC)) ? CHECK : ARMED;
            end
            CHECK: if (!toggled) begin
                state_n = IDLE;
                fail_n  = 1'b1;
            end else if (off_cnt == CNT_W'(MAX_CYC + 1)) begin
                state_n = IDLE;
                pass_n  = 1'b1;
            end else begin
                off_n = off_cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state    <= IDLE;
            off_cnt  <= '0;
            busy     <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            fail_off <= '0;
        end else begin
            state   <= state_n;
            off_cnt <= off_n;
            busy    <= (state_n != IDLE);
            pass    <= pass_n;
            fail    <= fail_n;
            if (fail_n) fail_off <= off_cnt;
        end
`ifdef TOGGLE_WINDOW_CHECKER_STICKY_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            fail_sticky <= 1'b0;
            fail_cnt    <= '0;
        end else if (fail_n) begin
            fail_sticky <= 1'b1;
            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        end
`endif
endmodule

// File: tb/tb_toggle_window_checker.sv
// tb_toggle_window_checker: drives default and MIN=MAX=1 checkers with shared streams against a run-level model
module tb_toggle_window_checker;
    localparam int N = 320;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, sig = 1'b0;
    logic busy0, pass0, fail0, busy1, pass1, fail1;
    logic [3:0] fo0;
    logic [1:0] fo1;
`ifdef TOGGLE_WINDOW_CHECKER_STICKY_EN
    logic st0, st1;
    logic [7:0] fc0, fc1;
`endif
    int vec = 0, err = 0;
    bit st[N], s[N], r[N];
    logic ob[2][N], op[2][N], of[2][N];
    logic [7:0] oo[2][N];
    bit eb[2][N], ep[2][N], ef[2][N];
    int eo[2][N];

    always #5 clk = ~clk;

    toggle_window_checker d0 (
        .clk(clk), .rst(rst), .start(start), .sig(sig),
        .busy(busy0), .pass(pass0), .fail(fail0),
`ifdef TOGGLE_WINDOW_CHECKER_STICKY_EN
        .fail_sticky(st0), .fail_cnt(fc0),
`endif
        .fail_off(fo0)
    );
    toggle_window_checker #(.MIN_CYC(1), .MAX_CYC(1)) d1 (
        .clk(clk), .rst(rst), .start(start), .sig(sig),
        .busy(busy1), .pass(pass1), .fail(fail1),
`ifdef TOGGLE_WINDOW_CHECKER_STICKY_EN
        .fail_sticky(st1), .fail_cnt(fc1),
`endif
        .fail_off(fo1)
    );

    // Stream starts with a reset cycle; sig alternates unless a test overrides it.
    task automatic clr();
        for (int k = 0; k < N; k++) begin
            st[k] = 0;
            s[k]  = k[0];
            r[k]  = 1;
        end
        r[0] = 0;
    endtask

    // Run-level model: each accepted start yields one verdict at a computed offset.
    task automatic model(input int i, input int mn, input int mx, input int n);
        int act = 0, S = 0, E = 0, fo = 0, hold = 0;
        bit isf = 0;
        for (int k = 0; k < n; k++) begin
            eb[i][k] = 0; ep[i][k] = 0; ef[i][k] = 0;
            if (k > 0 && !r[k-1]) begin act = 0; hold = 0; end
            if (act != 0 && k == E) begin
                if (isf) begin ef[i][k] = 1; hold = fo; end
                else ep[i][k] = 1;
                act = 0;
            end
            eb[i][k] = (act != 0) && k > S;
            eo[i][k] = hold;
            if (r[k] && st[k] && act == 0) begin
                S = k; act = 1; isf = 0; E = S + mx + 2;
                for (int j = S + 1 + mn; j <= S + 1 + mx; j++)
                    if (!isf && s[j] == s[j-1]) begin isf = 1; fo = j - S; E = j + 1; end
            end
        end
    endtask

    task automatic play(input int n);
        model(0, 1, 12, n);
        model(1, 1, 1, n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            ob[0][k] = busy0; op[0][k] = pass0; of[0][k] = fail0; oo[0][k] = {4'b0, fo0};
            ob[1][k] = busy1; op[1][k] = pass1; of[1][k] = fail1; oo[1][k] = {6'b0, fo1};
            start = st[k]; sig = s[k]; rst = r[k];
        end
        start = 0; rst = 1;
    endtask

    task automatic test_reset();
        clr();
        for (int k = 0; k < 6; k++) begin r[k] = 0; st[k] = 1; end
        play(10);
        for (int k = 1; k < 10; k++) for (int i = 0; i < 2; i++) begin
            vec++;
            if ({ob[i][k], op[i][k], of[i][k]} !== {eb[i][k], ep[i][k], ef[i][k]} || oo[i][k] !== 8'(eo[i][k])) begin
                err++;
                $display("FAIL reset k=%0d dut=%0d got b%b p%b f%b off%0d want b%b p%b f%b off%0d", k, i, ob[i][k], op[i][k], of[i][k], oo[i][k], eb[i][k], ep[i][k], ef[i][k], eo[i][k]);
            end
        end
    endtask

    task automatic test_pass();
        clr();
        st[3] = 1;
        play(22);
        for (int k = 1; k < 22; k++) for (int i = 0; i < 2; i++) begin
            vec++;
            if ({ob[i][k], op[i][k], of[i][k]} !== {eb[i][k], ep[i][k], ef[i][k]} || oo[i][k] !== 8'(eo[i][k])) begin
                err++;
                $display("FAIL pass k=%0d dut=%0d got b%b p%b f%b off%0d want b%b p%b f%b off%0d", k, i, ob[i][k], op[i][k], of[i][k], oo[i][k], eb[i][k], ep[i][k], ef[i][k], eo[i][k]);
            end
        end
    endtask

    task automatic test_fail();
        clr();
        st[3] = 1; s[8] = s[7];
        st[20] = 1; s[22] = s[21];
        play(40);
        for (int k = 1; k < 40; k++) for (int i = 0; i < 2; i++) begin
            vec++;
            if ({ob[i][k], op[i][k], of[i][k]} !== {eb[i][k], ep[i][k], ef[i][k]} || oo[i][k] !== 8'(eo[i][k])) begin
                err++;
                $display("FAIL fail k=%0d dut=%0d got b%b p%b f%b off%0d want b%b p%b f%b off%0d", k, i, ob[i][k], op[i][k], of[i][k], oo[i][k], eb[i][k], ep[i][k], ef[i][k], eo[i][k]);
            end
        end
    endtask

    task automatic test_out_of_window();
        clr();
        st[3] = 1; s[4] = s[3]; s[18] = s[17];
        play(24);
        for (int k = 1; k < 24; k++) for (int i = 0; i < 2; i++) begin
            vec++;
            if ({ob[i][k], op[i][k], of[i][k]} !== {eb[i][k], ep[i][k], ef[i][k]} || oo[i][k] !== 8'(eo[i][k])) begin
                err++;
                $display("FAIL outwin k=%0d dut=%0d got b%b p%b f%b off%0d want b%b p%b f%b off%0d", k, i, ob[i][k], op[i][k], of[i][k], oo[i][k], eb[i][k], ep[i][k], ef[i][k], eo[i][k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clr();
        st[3] = 1; st[7] = 1; st[17] = 1;
        play(36);
        for (int k = 1; k < 36; k++) for (int i = 0; i < 2; i++) begin
            vec++;
            if ({ob[i][k], op[i][k], of[i][k]} !== {eb[i][k], ep[i][k], ef[i][k]} || oo[i][k] !== 8'(eo[i][k])) begin
                err++;
                $display("FAIL b2b k=%0d dut=%0d got b%b p%b f%b off%0d want b%b p%b f%b off%0d", k, i, ob[i][k], op[i][k], of[i][k], oo[i][k], eb[i][k], ep[i][k], ef[i][k], eo[i][k]);
            end
        end
    endtask

    task automatic test_async_reset();
        clr();
        st[3] = 1; s[5] = s[4];
        st[14] = 1; r[21] = 0; r[22] = 0;
        st[26] = 1;
        play(45);
        for (int k = 1; k < 45; k++) for (int i = 0; i < 2; i++) begin
            vec++;
            if ({ob[i][k], op[i][k], of[i][k]} !== {eb[i][k], ep[i][k], ef[i][k]} || oo[i][k] !== 8'(eo[i][k])) begin
                err++;
                $display("FAIL arst k=%0d dut=%0d got b%b p%b f%b off%0d want b%b p%b f%b off%0d", k, i, ob[i][k], op[i][k], of[i][k], oo[i][k], eb[i][k], ep[i][k], ef[i][k], eo[i][k]);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            clr();
            for (int k = 1; k < N; k++) begin
                s[k]  = s[k-1] ^ ($urandom_range(0, 11) != 0);
                st[k] = ($urandom_range(0, 5) == 0);
                r[k]  = ($urandom_range(0, 79) != 0);
            end
            play(300);
            for (int k = 1; k < 300; k++) for (int i = 0; i < 2; i++) begin
                vec++;
                if ({ob[i][k], op[i][k], of[i][k]} !== {eb[i][k], ep[i][k], ef[i][k]} || oo[i][k] !== 8'(eo[i][k])) begin
                    err++;
                    $display("FAIL random t=%0d k=%0d dut=%0d got b%b p%b f%b off%0d want b%b p%b f%b off%0d", t, k, i, ob[i][k], op[i][k], of[i][k], oo[i][k], eb[i][k], ep[i][k], ef[i][k], eo[i][k]);
                end
            end
        end
    endtask

`ifdef TOGGLE_WINDOW_CHECKER_STICKY_EN
    task automatic test_sticky();
        int n0 = 0, n1 = 0;
        clr();
        st[3] = 1; s[8] = s[7];
        st[20] = 1; s[25] = s[24];
        st[40] = 1; s[42] = s[41];
        play(60);
        for (int k = 0; k < 60; k++) begin n0 += ef[0][k]; n1 += ef[1][k]; end
        vec++;
        if (st0 !== (n0 > 0) || fc0 !== 8'(n0)) begin
            err++;
            $display("FAIL sticky dut=0 got s%b c%0d want s%b c%0d", st0, fc0, n0 > 0, n0);
        end
        vec++;
        if (st1 !== (n1 > 0) || fc1 !== 8'(n1)) begin
            err++;
            $display("FAIL sticky dut=1 got s%b c%0d want s%b c%0d", st1, fc1, n1 > 0, n1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_out_of_window();
        test_back_to_back();
        test_async_reset();
        test_random();
`ifdef TOGGLE_WINDOW_CHECKER_STICKY_EN
        test_sticky();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/toggle_window_checker.md
Name: toggle_window_checker

Overview:
- Synthesizable on-chip checker, the RTL counterpart of a windowed "signal must toggle every cycle" property.
- A `start` pulse arms the checker. It then verifies that `sig` differs from its previous-cycle value at every cycle inside a programmable window of offsets after `start`.
- Reports a one-cycle pass or fail pulse, plus the offset of the first violation.
- Sits beside a toggling-stimulus source (or any heartbeat/strobe) as a hardware monitor feeding status/interrupt logic.

Parameters:
- MIN_CYC, 1, first checked cycle of the window, counted after the cycle following `start`; legal 1..MAX_CYC.
- MAX_CYC, 12, last checked cycle of the window; legal MIN_CYC..254.
- CNT_W, $clog2(MAX_CYC+3), width of the offset counter and `fail_off`; derived, not to be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  arm request; sampled high in IDLE only.
- sig  in  1  monitored signal.
- busy  out  1  high while a check is in progress (ARMED/CHECK).
- pass  out  1  one-cycle pulse: every window cycle toggled.
- fail  out  1  one-cycle pulse: first non-toggle inside the window.
- fail_off  out  CNT_W  offset of the first violation; held until the next `fail`.

Behaviour:
- Offsets: the cycle in which `start` is sampled is offset 0. The window is offsets 1+MIN_CYC..1+MAX_CYC; with defaults that is offsets 2..13.
- sig_q: registers `sig` every cycle regardless of state. Reset value 0.
- Toggle condition at offset j: sig(j) != sig_q, where sig_q holds sig(j-1).
- States:
  - IDLE: on start=1, go to ARMED and set off_cnt=1.
  - ARMED: off_cnt increments each cycle; when off_cnt == MIN_CYC, go to CHECK on the next cycle. Toggles are not checked in ARMED.
  - CHECK: every cycle, if no toggle, go to IDLE, pulse `fail` next cycle, and load `fail_off` = off_cnt. Otherwise, if off_cnt == 1+MAX_CYC, go to IDLE and pulse `pass` next cycle. Otherwise increment off_cnt.
- Latency: `fail` asserts at offset j+1 for a violation at offset j. `pass` asserts at offset MAX_CYC+2 (14 with defaults).
- `busy` is registered. It is high from offset 1 through the cycle of the final evaluation, and low in the cycle `pass`/`fail` is high.
- `start` while busy is ignored: no restart and no queueing. `start` in the cycle `pass`/`fail` is high is accepted (checker is already IDLE).
- Toggle behaviour outside the window (offsets 1..MIN_CYC, or after MAX_CYC+1) is never judged.
- `pass` and `fail` are never high in the same cycle.
- Reset, async mid-operation:
  - state to IDLE;
  - off_cnt, sig_q, busy, pass, fail, fail_off all to 0;
  - no pulse on deassertion.
- off_cnt never wraps: it is bounded by 1+MAX_CYC < 2^CNT_W.

Optional Feature:
- Macro: TOGGLE_WINDOW_CHECKER_STICKY_EN.
- Defined:
  - adds output `fail_sticky` (1 bit), set by any `fail` and cleared only by reset;
  - adds output `fail_cnt` (8 bits), incremented per `fail` and saturating at 255;
  - reset values 0.
- Undefined: neither port nor its registers exist; core behaviour is identical.

Decomposition:
- Package toggle_chk_pkg:
  - state enum {IDLE, ARMED, CHECK};
  - constant FAIL_CNT_W = 8;
  - localparam function computing CNT_W from MAX_CYC.
- Sub-module toggle_detect:
  - registers `sig` into sig_q and outputs combinational `toggled = sig ^ sig_q`;
  - same clk/rst.
- The FSM and counter stay in the top module.
- Elaboration-time assertion rejects MIN_CYC < 1 or MIN_CYC > MAX_CYC.

Test Plan:
- Defaults; start at offset 0; `sig` alternates 1,0,1,... from offset 1 → `pass`=1 only at offset 14; `busy` high offsets 1..13; `fail` never high.
- `sig` alternates except sig(5)==sig(4) → `fail` at offset 6, `fail_off`=5, `busy` low at offset 6, no `pass`.
- Non-toggle only at offset 1 and at offset 15 → `pass` at offset 14 (out-of-window ignored).
- Second `start` at offset 4 during a passing run → single `pass` at offset 14; `start` re-asserted at offset 14 → new run, `pass` at offset 28.
- rst=0 at offset 7 for 2 cycles → all outputs 0 immediately, state IDLE, no pulse after release; fresh start → normal pass 14 cycles later.
- MIN_CYC=MAX_CYC=1: violation at offset 2 → `fail` at offset 3, `fail_off`=2. STICKY_EN build: three failing runs → `fail_sticky`=1, `fail_cnt`=3.
